// File: rtl/weight_loader_pkg.sv
// Shared types for the weight tile loader.
//   state_t : fill FSM states
//   tag_t   : per-read tag {valid, row, col} carried alongside the memory latency
// Row/col index fields are IDX_W bits, which covers arrays up to 256x256.
package weight_loader_pkg;

  localparam int IDX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag delay line: tags enter on the read strobe cycle and appear at
// tag_out in the cycle the matching mem_data is valid.
//   clk, reset : clock, synchronous active-high reset (clears every stage)
//   tag_in     : tag pushed this cycle
//   tag_out    : tag whose data is on mem_data now
//   empty      : no tag remains in flight beyond the one now at tag_out,
//                i.e. the pipe will be empty after this cycle if nothing is
//                pushed; lets the FSM leave DRAIN on the last capture cycle
module rd_tag_pipe
  import weight_loader_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic empty
);

  tag_t stg [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    end else begin
      stg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  assign tag_out = stg[DEPTH-1];

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++)
      if (stg[i].valid) empty = 1'b0;
  end

endmodule

// File: rtl/weight_tile_loader.sv
// Weight tile loader: on start, streams kk*nf words from a synchronous weight
// memory (one read per cycle) and packs them into a zero-padded
// ARRAY_ROWS x ARRAY_COLS tile, element (r,c) at
// weight_out[(r*ARRAY_COLS+c)*DATA_SIZE +: DATA_SIZE].
//   clk, reset                     : clock, synchronous active-high reset
//   start                          : begin a fill (sampled only in IDLE)
//   base_address, weight_size,
//   number_filters, filter_offset  : fill configuration, latched on start
//   mem_addr, mem_rd_en, mem_data  : weight memory port (MEM_LATENCY read)
//   weight_out, weight_valid       : packed tile and its valid flag
//   busy, done, error              : status
module weight_tile_loader
  import weight_loader_pkg::*;
#(
  parameter int DATA_SIZE   = 16,
  parameter int ARRAY_ROWS  = 9,
  parameter int ARRAY_COLS  = 9,
  parameter int ADDR_WIDTH  = 15,
  parameter int DIM_SIZE    = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [ADDR_WIDTH-1:0]                    base_address,
  input  logic [DIM_SIZE-1:0]                      weight_size,
  input  logic [DIM_SIZE-1:0]                      number_filters,
  input  logic [DIM_SIZE-1:0]                      filter_offset,
  output logic [ADDR_WIDTH-1:0]                    mem_addr,
  output logic                                     mem_rd_en,
  input  logic [DATA_SIZE-1:0]                     mem_data,
  output logic [DATA_SIZE*ARRAY_ROWS*ARRAY_COLS-1:0] weight_out,
  output logic                                     weight_valid,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     error
);

  localparam int TILE_W = DATA_SIZE * ARRAY_ROWS * ARRAY_COLS;
  localparam int LSB_W  = $clog2(TILE_W);
  localparam int KK_W   = 2 * DIM_SIZE;
  localparam int PRD_W  = 3 * DIM_SIZE;
  localparam logic [KK_W-1:0]     ROWS_L = KK_W'(ARRAY_ROWS);
  localparam logic [DIM_SIZE-1:0] COLS_L = DIM_SIZE'(ARRAY_COLS);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] base_r, sa_r, idx;
  logic [DIM_SIZE-1:0]   k_r, nf_r, off_r;
  logic [KK_W-1:0]       kk;
  logic [IDX_W-1:0]      kk_m1, nf_m1, row, col;
  logic                  cfg_bad, accept, last_rd;
  tag_t                  tag_in, tag_out;
  logic                  pipe_empty;
  logic [LSB_W-1:0]      cap_lsb;

  assign kk      = KK_W'(k_r) * KK_W'(k_r);
  assign cfg_bad = (k_r == '0) || (nf_r == '0) || (kk > ROWS_L) || (nf_r > COLS_L);
  assign accept  = (state == IDLE) && start;
  assign last_rd = (row == kk_m1) && (col == nf_m1);

  always_comb begin
    state_n   = state;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (start) state_n = CHECK;
      CHECK: state_n = cfg_bad ? DONE : ISSUE;
      ISSUE: begin
        mem_rd_en = 1'b1;
        mem_addr  = sa_r + idx;
        if (last_rd) state_n = DRAIN;
      end
      DRAIN: if (pipe_empty) state_n = DONE;
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Config latch, derived fill geometry, issue counters, status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r       <= '0;
      k_r          <= '0;
      nf_r         <= '0;
      off_r        <= '0;
      sa_r         <= '0;
      kk_m1        <= '0;
      nf_m1        <= '0;
      idx          <= '0;
      row          <= '0;
      col          <= '0;
      error        <= 1'b0;
      weight_valid <= 1'b0;
    end else begin
      if (accept) begin
        base_r       <= base_address;
        k_r          <= weight_size;
        nf_r         <= number_filters;
        off_r        <= filter_offset;
        error        <= 1'b0;
        weight_valid <= 1'b0;
      end
      if (state == CHECK) begin
        // Start address wraps modulo 2^ADDR_WIDTH.
        sa_r  <= base_r + ADDR_WIDTH'(PRD_W'(off_r) * PRD_W'(kk));
        kk_m1 <= IDX_W'(kk - 1'b1);
        nf_m1 <= IDX_W'(nf_r - 1'b1);
        idx   <= '0;
        row   <= '0;
        col   <= '0;
        if (cfg_bad) error <= 1'b1;
      end
      if (state == ISSUE) begin
        idx <= idx + 1'b1;
        if (row == kk_m1) begin
          row <= '0;
          col <= col + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end
      if (state == DRAIN && pipe_empty) weight_valid <= 1'b1;
    end
  end

  assign tag_in = '{valid: (state == ISSUE), row: row, col: col};

  rd_tag_pipe #(.DEPTH(MEM_LATENCY)) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .empty   (pipe_empty)
  );

  assign cap_lsb = LSB_W'((int'(tag_out.row) * ARRAY_COLS + int'(tag_out.col)) * DATA_SIZE);

  // Tile is cleared as the start is accepted, so it reads zero from CHECK on.
  always_ff @(posedge clk) begin
    if (reset || accept)  weight_out <= '0;
    else if (tag_out.valid) weight_out[cap_lsb +: DATA_SIZE] <= mem_data;
  end

endmodule
